counter_mode_sequencer: RTL

- Run-control block for the board's 4-bit up/down binary counter datapath.
- Latches a count mode, lower/upper bounds and prescaler on start; generates a step tick from the prescaler.
- Sequences load, enable and direction of a sub-counter, with wrap, reversal and one-shot completion handling.
- Sits between the front-panel/config logic and the display/LED path driven by count.

---
 rtl/counter_pkg.sv | 18 +
 rtl/up_down_counter.sv | 28 ++
 rtl/counter_mode_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter run-control slice:
// mode encodings, sequencer states and default widths.
package counter_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int PRESC_W_DEF = 16;

  localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
  localparam logic [1:0] MODE_DOWN_WRAP = 2'b01;
  localparam logic [1:0] MODE_PING_PONG = 2'b10;
  localparam logic [1:0] MODE_ONE_SHOT  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/up_down_counter.sv
// Plain loadable up/down counter; all bound handling lives in the sequencer.
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= load_val;
    end else if (en) begin
      q_q <= up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_mode_sequencer.sv
// Run-control for the 4-bit up/down counter: latches config on start, divides
// the clock into step ticks and steers the sub-counter per count mode.
module counter_mode_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic               cfg_err
);

  seq_state_t         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cnt_load;
  logic [WIDTH-1:0]   cnt_load_val;
  logic               cnt_en;
  logic               cnt_up;
  logic [WIDTH-1:0]   count_q;
  logic               tick;

  up_down_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .q        (count_q)
  );

  assign tick = (pcnt_q == presc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      dir_q     <= 1'b1;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // stop always takes precedence, so a stop cycle never steps or pulses
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    presc_d      = presc_q;
    pcnt_d       = pcnt_q;
    dir_d        = dir_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = cfg_err_q;
    cnt_load     = 1'b0;
    cnt_load_val = count_q;
    cnt_en       = 1'b0;
    cnt_up       = dir_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (lo > hi) begin
            cfg_err_d = 1'b1;
          end else begin
            mode_d       = mode;
            lo_d         = lo;
            hi_d         = hi;
            presc_d      = presc;
            cfg_err_d    = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = (mode == MODE_DOWN_WRAP) ? hi : lo;
            dir_d        = (mode != MODE_DOWN_WRAP);
            pcnt_d       = '0;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
          if (tick) begin
            case (mode_q)
              MODE_UP_WRAP: begin
                if (count_q == hi_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = lo_q;
                  wrap_d       = 1'b1;
                end else begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b1;
                end
              end
              MODE_DOWN_WRAP: begin
                if (count_q == lo_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = hi_q;
                  wrap_d       = 1'b1;
                end else begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b0;
                end
              end
              // A single-value window cannot move, so it just flips direction
              MODE_PING_PONG: begin
                cnt_en = 1'b1;
                if (lo_q == hi_q) begin
                  cnt_en = 1'b0;
                  dir_d  = ~dir_q;
                  wrap_d = 1'b1;
                end else if (dir_q && (count_q == hi_q)) begin
                  cnt_up = 1'b0;
                  dir_d  = 1'b0;
                  wrap_d = 1'b1;
                end else if (!dir_q && (count_q == lo_q)) begin
                  cnt_up = 1'b1;
                  dir_d  = 1'b1;
                  wrap_d = 1'b1;
                end
              end
              default: begin
                if (count_q == hi_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b1;
                end
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign busy    = (state_q == RUN);
  assign wrap    = wrap_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
